spi_initiator: RTL

SPI mode-0 initiator (master) for MCP23S17-style register access. It frames one fixed 24-bit transaction per request: opcode (device address + R/W), register address, and one data byte. It drives `sclk_o`, `csn_o` and `mosi_o`, and samples `miso_i`. It sits between a local control interface (start/busy/done) and the external SPI pins, or a responder model on the bench.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_clk_div.sv | 29 ++
 rtl/spi_initiator.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the MCP23S17-style SPI initiator.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        GAP
    } spi_init_state_t;

    localparam int unsigned   SPI_FRAME_BITS  = 24;
    localparam logic [3:0]    MCP_OPCODE_BASE = 4'b0100;
    localparam logic          SPI_RD          = 1'b1;
    localparam logic          SPI_WR          = 1'b0;

    // Opcode, register address, then the data byte (zero for reads).
    function automatic logic [SPI_FRAME_BITS-1:0] spi_frame(
        input logic [6:0] dev,
        input logic       rw,
        input logic [7:0] addr,
        input logic [7:0] data
    );
        return {dev, rw, addr, (rw == SPI_RD) ? 8'h00 : data};
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick_c is high on the last cycle of every CLK_DIV-cycle window.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic sclk_i,
    input  logic clr_i,
    output logic tick_c
);

    localparam int unsigned      CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick_c = (cnt_q == CNT_LAST);
        cnt_d  = tick_c ? '0 : CNT_W'(cnt_q + CNT_W'(1));
    end

    always_ff @(posedge sclk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_initiator.sv
// SPI mode-0 initiator issuing one 24-bit opcode/address/data frame per request.
module spi_initiator
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter logic [6:0]  DEV_ADDR = {MCP_OPCODE_BASE, 3'b000}
) (
    input  logic       sclk_i,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       sclk_o,
    output logic       csn_o,
    output logic       mosi_o,
    input  logic       miso_i
);

    localparam int unsigned      BIT_W    = 5;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SPI_FRAME_BITS - 1);

    spi_init_state_t state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       rd_q, rd_d;
    logic             sclk_q, sclk_d;
    logic             csn_q, csn_d;
    logic             mosi_q, mosi_d;
    logic [22:0]      shreg_q, shreg_d;
    logic [7:0]       rx_q, rx_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             high_q, high_d;
    logic             rw_q, rw_d;

    logic                      accept_c;
    logic                      tick_c;
    logic [SPI_FRAME_BITS-1:0] frame_c;

    assign frame_c = spi_frame(DEV_ADDR, rw, reg_addr, wr_data);

    // Divider restarts on accept so the lead-in is exactly CLK_DIV cycles.
    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .sclk_i (sclk_i),
        .clr_i  (rst | accept_c),
        .tick_c (tick_c)
    );

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rd_d     = rd_q;
        sclk_d   = sclk_q;
        csn_d    = csn_q;
        mosi_d   = mosi_q;
        shreg_d  = shreg_q;
        rx_d     = rx_q;
        bit_d    = bit_q;
        high_d   = high_q;
        rw_d     = rw_q;
        accept_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    state_d  = LEAD;
                    busy_d   = 1'b1;
                    csn_d    = 1'b0;
                    sclk_d   = 1'b0;
                    mosi_d   = frame_c[SPI_FRAME_BITS-1];
                    shreg_d  = frame_c[SPI_FRAME_BITS-2:0];
                    rw_d     = rw;
                    bit_d    = '0;
                    high_d   = 1'b0;
                end
            end
            LEAD: begin
                if (tick_c) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                    high_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (tick_c) begin
                    if (high_q) begin
                        // End of high half: capture miso, drop sclk, present the next bit.
                        rx_d    = {rx_q[6:0], miso_i};
                        sclk_d  = 1'b0;
                        mosi_d  = shreg_q[22];
                        shreg_d = {shreg_q[21:0], 1'b0};
                        high_d  = 1'b0;
                    end else if (bit_q == LAST_BIT) begin
                        state_d = GAP;
                        csn_d   = 1'b1;
                        mosi_d  = 1'b0;
                    end else begin
                        bit_d  = BIT_W'(bit_q + BIT_W'(1));
                        sclk_d = 1'b1;
                        high_d = 1'b1;
                    end
                end
            end
            GAP: begin
                if (tick_c) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (rw_q == SPI_RD) begin
                        rd_d = rx_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sclk_i) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 8'h00;
            sclk_q  <= 1'b0;
            csn_q   <= 1'b1;
            mosi_q  <= 1'b0;
            shreg_q <= '0;
            rx_q    <= 8'h00;
            bit_q   <= '0;
            high_q  <= 1'b0;
            rw_q    <= SPI_WR;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            sclk_q  <= sclk_d;
            csn_q   <= csn_d;
            mosi_q  <= mosi_d;
            shreg_q <= shreg_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            high_q  <= high_d;
            rw_q    <= rw_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_data = rd_q;
    assign sclk_o  = sclk_q;
    assign csn_o   = csn_q;
    assign mosi_o  = mosi_q;

endmodule
